// File: rtl/rlc_stream_encoder.sv
// rlc_stream_encoder: streaming run-length coder for zig-zag ordered 8x8 blocks.
// Accepts one coefficient per cycle and emits DC, (run, level), ZRL and EOB
// symbols through a single output register with valid/ready handshake.
// Optional feature macro: RLC_REPEAT_EN -- adds a one-entry hold register that
// merges consecutive identical AC/ZRL symbols into one symbol with cnt > 1.
module rlc_stream_encoder #(
    parameter int COEF_W  = 11,
    parameter int BLK_LEN = 64,
    parameter int RUN_W   = 4,
    parameter int CNT_W   = 4,
    parameter int NUM_BLK = 1730
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RUN_W-1:0]         out_run,
    output logic signed [COEF_W-1:0] out_level,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     out_dc,
    output logic                     out_eob,
    output logic [10:0]              blk_idx,
    output logic                     frame_done
);

    localparam int IDX_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

    localparam logic [1:0] ST_DC  = 2'd0;
    localparam logic [1:0] ST_AC  = 2'd1;
    localparam logic [1:0] ST_ZRL = 2'd2;
    localparam logic [1:0] ST_EOB = 2'd3;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLK_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [10:0]       BLK_LAST  = 11'(NUM_BLK - 1);
    localparam logic [10:0]       BLK_ONE   = 11'd1;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]               state_reg, state_next;
    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic [IDX_W-1:0]         zrun_reg, zrun_next;
    logic [IDX_W-1:0]         zrl_left_reg, zrl_left_next;
    logic [RUN_W-1:0]         pend_run_reg, pend_run_next;
    logic signed [COEF_W-1:0] pend_level_reg, pend_level_next;
    logic                     pend_last_reg, pend_last_next;
    logic                     eob_sent_reg, eob_sent_next;
    logic                     alive_reg;

    // Output register
    logic                     out_valid_reg;
    logic [RUN_W-1:0]         out_run_reg;
    logic signed [COEF_W-1:0] out_level_reg;
    logic [CNT_W-1:0]         out_cnt_reg;
    logic                     out_dc_reg;
    logic                     out_eob_reg;
    logic [10:0]              blk_idx_reg;
    logic                     frame_done_reg;

    // Symbol produced by the coder this cycle (before optional merging)
    logic                     gen_valid;
    logic [RUN_W-1:0]         gen_run;
    logic signed [COEF_W-1:0] gen_level;
    logic                     gen_dc;
    logic                     gen_eob;

    // What gets written into the output register this cycle
    logic                     load_out;
    logic [RUN_W-1:0]         load_run;
    logic signed [COEF_W-1:0] load_level;
    logic [CNT_W-1:0]         load_cnt;
    logic                     load_dc;
    logic                     load_eob;

    logic                     out_adv;
    logic                     out_take;
    logic                     in_ready_int;
    logic                     in_fire;
    logic                     coef_nz;
    logic                     is_last;
    logic [IDX_W-1:0]         zrl_n;
    logic [RUN_W-1:0]         zrun_low;
    logic                     eob_free;

    // The output register can take a new symbol when empty or being drained.
    assign out_adv      = !out_valid_reg || out_ready;
    assign out_take     = out_valid_reg && out_ready;
    assign in_ready_int = alive_reg && ((state_reg == ST_DC) || (state_reg == ST_AC)) && out_adv;
    assign in_fire      = in_valid && in_ready_int;
    assign coef_nz      = |in_coef;
    assign is_last      = (idx_reg == IDX_LAST);
    assign zrl_n        = zrun_reg >> RUN_W;
    assign zrun_low     = zrun_reg[RUN_W-1:0];

    // Coder: walks the block, counts zero runs and produces one symbol per cycle.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        zrun_next       = zrun_reg;
        zrl_left_next   = zrl_left_reg;
        pend_run_next   = pend_run_reg;
        pend_level_next = pend_level_reg;
        pend_last_next  = pend_last_reg;
        eob_sent_next   = eob_sent_reg;
        gen_valid       = 1'b0;
        gen_run         = '0;
        gen_level       = '0;
        gen_dc          = 1'b0;
        gen_eob         = 1'b0;
        case (state_reg)
            ST_DC: begin
                if (in_fire) begin
                    gen_valid  = 1'b1;
                    gen_dc     = 1'b1;
                    gen_level  = in_coef;
                    idx_next   = idx_reg + IDX_ONE;
                    zrun_next  = '0;
                    state_next = ST_AC;
                end
            end
            ST_AC: begin
                if (in_fire) begin
                    idx_next = is_last ? '0 : idx_reg + IDX_ONE;
                    if (!coef_nz) begin
                        // Trailing zeros of the block are simply dropped.
                        zrun_next = is_last ? '0 : zrun_reg + IDX_ONE;
                        if (is_last) begin
                            state_next = ST_EOB;
                        end
                    end else begin
                        zrun_next = '0;
                        gen_valid = 1'b1;
                        if (zrl_n != '0) begin
                            // First ZRL goes out now; the rest and the level wait.
                            gen_run         = RUN_MAX;
                            gen_level       = '0;
                            zrl_left_next   = zrl_n - IDX_ONE;
                            pend_run_next   = zrun_low;
                            pend_level_next = in_coef;
                            pend_last_next  = is_last;
                            state_next      = ST_ZRL;
                        end else begin
                            gen_run    = zrun_low;
                            gen_level  = in_coef;
                            state_next = is_last ? ST_EOB : ST_AC;
                        end
                    end
                end
            end
            ST_ZRL: begin
                if (out_adv) begin
                    gen_valid = 1'b1;
                    if (zrl_left_reg != '0) begin
                        gen_run       = RUN_MAX;
                        gen_level     = '0;
                        zrl_left_next = zrl_left_reg - IDX_ONE;
                    end else begin
                        gen_run    = pend_run_reg;
                        gen_level  = pend_level_reg;
                        state_next = pend_last_reg ? ST_EOB : ST_AC;
                    end
                end
            end
            default: begin
                // ST_EOB: send one EOB, then wait for the consumer to take it.
                if (!eob_sent_reg && eob_free) begin
                    gen_valid     = 1'b1;
                    gen_eob       = 1'b1;
                    eob_sent_next = 1'b1;
                end
                if (eob_sent_reg && out_take && out_eob_reg) begin
                    state_next    = ST_DC;
                    eob_sent_next = 1'b0;
                end
            end
        endcase
    end

    // Control registers of the coder.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg      <= ST_DC;
            idx_reg        <= '0;
            zrun_reg       <= '0;
            zrl_left_reg   <= '0;
            pend_run_reg   <= '0;
            pend_level_reg <= '0;
            pend_last_reg  <= 1'b0;
            eob_sent_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            zrun_reg       <= zrun_next;
            zrl_left_reg   <= zrl_left_next;
            pend_run_reg   <= pend_run_next;
            pend_level_reg <= pend_level_next;
            pend_last_reg  <= pend_last_next;
            eob_sent_reg   <= eob_sent_next;
        end
    end

    // Holds in_ready low through reset and releases it on the first edge after.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            alive_reg <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
        end
    end

`ifdef RLC_REPEAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [CNT_W-1:0] CNT_MERGE_LIM = CNT_W'((1 << CNT_W) - 2);

    logic                     hold_valid_reg, hold_valid_next;
    logic [RUN_W-1:0]         hold_run_reg, hold_run_next;
    logic signed [COEF_W-1:0] hold_level_reg, hold_level_next;
    logic [CNT_W-1:0]         hold_cnt_reg, hold_cnt_next;
    logic                     hold_match;
    logic                     hold_flush;

    // EOB may only leave once the held symbol has been flushed ahead of it.
    assign eob_free   = out_adv && !hold_valid_reg;
    assign hold_match = hold_valid_reg && (hold_run_reg == gen_run) && (hold_level_reg == gen_level);
    assign hold_flush = (state_reg == ST_EOB) && !eob_sent_reg && out_adv && hold_valid_reg;

    // Merge stage: DC/EOB bypass the hold register, AC/ZRL are merged or flushed.
    always_comb begin
        load_out        = 1'b0;
        load_run        = gen_run;
        load_level      = gen_level;
        load_cnt        = CNT_ONE;
        load_dc         = gen_dc;
        load_eob        = gen_eob;
        hold_valid_next = hold_valid_reg;
        hold_run_next   = hold_run_reg;
        hold_level_next = hold_level_reg;
        hold_cnt_next   = hold_cnt_reg;
        if (gen_valid) begin
            if (gen_dc || gen_eob) begin
                load_out = 1'b1;
            end else if (!hold_valid_reg) begin
                hold_valid_next = 1'b1;
                hold_run_next   = gen_run;
                hold_level_next = gen_level;
                hold_cnt_next   = CNT_ONE;
            end else if (hold_match && (hold_cnt_reg < CNT_MERGE_LIM)) begin
                hold_cnt_next = hold_cnt_reg + CNT_ONE;
            end else begin
                // Either the count saturates or a different symbol arrived.
                load_out   = 1'b1;
                load_run   = hold_run_reg;
                load_level = hold_level_reg;
                load_dc    = 1'b0;
                load_eob   = 1'b0;
                if (hold_match) begin
                    load_cnt        = CNT_MAX;
                    hold_valid_next = 1'b0;
                end else begin
                    load_cnt        = hold_cnt_reg;
                    hold_run_next   = gen_run;
                    hold_level_next = gen_level;
                    hold_cnt_next   = CNT_ONE;
                end
            end
        end else if (hold_flush) begin
            load_out        = 1'b1;
            load_run        = hold_run_reg;
            load_level      = hold_level_reg;
            load_cnt        = hold_cnt_reg;
            load_dc         = 1'b0;
            load_eob        = 1'b0;
            hold_valid_next = 1'b0;
        end
    end

    // Hold register for the symbol currently being merged.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold_valid_reg <= 1'b0;
            hold_run_reg   <= '0;
            hold_level_reg <= '0;
            hold_cnt_reg   <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            hold_run_reg   <= hold_run_next;
            hold_level_reg <= hold_level_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end
`else
    assign eob_free   = out_adv;
    assign load_out   = gen_valid;
    assign load_run   = gen_run;
    assign load_level = gen_level;
    assign load_cnt   = CNT_ONE;
    assign load_dc    = gen_dc;
    assign load_eob   = gen_eob;
`endif

    // Output register: loaded only when free, fields held while stalled.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid_reg <= 1'b0;
            out_run_reg   <= '0;
            out_level_reg <= '0;
            out_cnt_reg   <= '0;
            out_dc_reg    <= 1'b0;
            out_eob_reg   <= 1'b0;
        end else if (load_out) begin
            out_valid_reg <= 1'b1;
            out_run_reg   <= load_run;
            out_level_reg <= load_level;
            out_cnt_reg   <= load_cnt;
            out_dc_reg    <= load_dc;
            out_eob_reg   <= load_eob;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Block counter advances on each accepted EOB; frame_done is sticky at wrap.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            blk_idx_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else if (out_take && out_eob_reg) begin
            if (blk_idx_reg == BLK_LAST) begin
                blk_idx_reg    <= '0;
                frame_done_reg <= 1'b1;
            end else begin
                blk_idx_reg <= blk_idx_reg + BLK_ONE;
            end
        end
    end

    assign in_ready   = in_ready_int;
    assign out_valid  = out_valid_reg;
    assign out_run    = out_run_reg;
    assign out_level  = out_level_reg;
    assign out_cnt    = out_cnt_reg;
    assign out_dc     = out_dc_reg;
    assign out_eob    = out_eob_reg;
    assign blk_idx    = blk_idx_reg;
    assign frame_done = frame_done_reg;

endmodule
